// File: rtl/ioctl_pkg.sv
// Shared types and default widths for the ioctl download transmitter.
// Imported by the transmitter top and its byte FIFO.
package ioctl_pkg;

  localparam int unsigned IoctlAddrW  = 25;
  localparam int unsigned IoctlIndexW = 8;
  localparam int unsigned IoctlGapW   = 4;
  localparam int unsigned IoctlDataW  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWrite,
    StGap,
    StPost
  } ioctl_state_e;

  // Cycles still to spend in GAP after the strobe cycle; a gap of 0 behaves as 1.
  function automatic logic [IoctlGapW-1:0] gap_reload(input logic [IoctlGapW-1:0] gap);
    return (gap == '0) ? '0 : gap - IoctlGapW'(1);
  endfunction

endpackage

// File: rtl/ioctl_tx_fifo.sv
// Small byte FIFO between the source stream and the ioctl write strobes.
// Full/empty are registered; flush empties it in one cycle.
module ioctl_tx_fifo
  import ioctl_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = IoctlDataW
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  cnt_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Simultaneous push and pop leaves occupancy unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      cnt_q <= cnt_d;
      full  <= (cnt_d == CntW'(Depth));
      empty <= (cnt_d == '0);
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/ioctl_tx.sv
// Streams source bytes out as ioctl download write strobes with a programmable
// idle gap, framed by ioctl_download; supports abort and zero-length transfers.
module ioctl_tx
  import ioctl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = IoctlAddrW
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   start,
  input  logic [IoctlIndexW-1:0] index,
  input  logic [ADDR_W-1:0]      length,
  input  logic [IoctlGapW-1:0]   gap,
  input  logic                   abort,
  input  logic [IoctlDataW-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   ioctl_download,
  output logic [IoctlIndexW-1:0] ioctl_index,
  output logic                   ioctl_wr,
  output logic [ADDR_W-1:0]      ioctl_addr,
  output logic [IoctlDataW-1:0]  ioctl_dout,
  output logic                   busy,
  output logic                   done
);

  ioctl_state_e          state_q;
  logic [ADDR_W-1:0]     len_q;
  logic [IoctlGapW-1:0]  gap_q;
  logic [IoctlGapW-1:0]  gap_cnt_q;
  logic [ADDR_W-1:0]     wr_cnt_q;
  logic [ADDR_W-1:0]     acc_cnt_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [IoctlDataW-1:0] fifo_rdata;
  logic                  push;
  logic                  pop;

  // Only bytes that belong to the current transfer are ever taken from the source.
  assign s_ready = busy & ~fifo_full & (acc_cnt_q < len_q);
  assign push    = s_valid & s_ready;
  assign pop     = (state_q == StWrite) & ~fifo_empty & ~abort;

  ioctl_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (IoctlDataW)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .flush   (abort),
    .push    (push),
    .wdata   (s_data),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= StIdle;
      len_q          <= '0;
      gap_q          <= '0;
      gap_cnt_q      <= '0;
      wr_cnt_q       <= '0;
      acc_cnt_q      <= '0;
      ioctl_download <= 1'b0;
      ioctl_index    <= '0;
      ioctl_wr       <= 1'b0;
      ioctl_addr     <= '0;
      ioctl_dout     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      ioctl_wr <= 1'b0;
      done     <= 1'b0;
      if (push) begin
        acc_cnt_q <= acc_cnt_q + ADDR_W'(1);
      end

      // Abort wins over everything, including a strobe due this cycle.
      if (abort) begin
        state_q        <= StIdle;
        ioctl_download <= 1'b0;
        busy           <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q        <= StPre;
              len_q          <= length;
              gap_q          <= gap;
              ioctl_index    <= index;
              wr_cnt_q       <= '0;
              acc_cnt_q      <= '0;
              ioctl_download <= 1'b1;
              busy           <= 1'b1;
            end
          end
          StPre: begin
            state_q <= (len_q == '0) ? StPost : StWrite;
          end
          StWrite: begin
            if (!fifo_empty) begin
              ioctl_wr   <= 1'b1;
              ioctl_addr <= wr_cnt_q;
              ioctl_dout <= fifo_rdata;
              wr_cnt_q   <= wr_cnt_q + ADDR_W'(1);
              gap_cnt_q  <= gap_reload(gap_q);
              state_q    <= StGap;
            end
          end
          StGap: begin
            if (gap_cnt_q == '0) begin
              state_q <= (wr_cnt_q < len_q) ? StWrite : StPost;
            end else begin
              gap_cnt_q <= gap_cnt_q - IoctlGapW'(1);
            end
          end
          StPost: begin
            state_q        <= StIdle;
            ioctl_download <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b1;
          end
          default: begin
            state_q        <= StIdle;
            ioctl_download <= 1'b0;
            busy           <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ioctl_tx.sv
// Bench for ioctl_tx: directed and randomized transfers checked against a
// behavioural model of strobe order, addressing, spacing and completion timing.
module tb_ioctl_tx;

  localparam int unsigned AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    index;
  logic [AW-1:0] length;
  logic [3:0]    gap;
  logic          abort;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          busy;
  logic          done;

  ioctl_tx #(
    .FIFO_DEPTH (4),
    .ADDR_W     (AW)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .start          (start),
    .index          (index),
    .length         (length),
    .gap            (gap),
    .abort          (abort),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Observed activity
  int st_addr[$];
  int st_data[$];
  int st_cyc[$];
  int done_n;
  int done_cyc;
  int dl_n;

  // Source model state
  logic [7:0] src_q[$];
  logic [7:0] ref_bytes[$];
  int  acc_cyc[$];
  int  acc_n;
  int  stall_at  = -1;
  int  stall_len = 0;
  int  stall_cnt = 0;
  int  drop_pct  = 0;
  bit  took;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    st_addr.delete();
    st_data.delete();
    st_cyc.delete();
    done_n   = 0;
    done_cyc = 0;
    dl_n     = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk_sys);
      if (ioctl_wr) begin
        st_addr.push_back(int'(ioctl_addr));
        st_data.push_back(int'(ioctl_dout));
        st_cyc.push_back(cyc);
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (ioctl_download) dl_n++;
    end
  end

  // Source: offers queued bytes with optional random drops and one scripted stall.
  initial begin
    forever begin
      @(negedge clk_sys);
      took = s_valid && s_ready;
      if (took) acc_cyc.push_back(cyc);
      @(posedge clk_sys);
      #1;
      if (took && src_q.size() > 0) begin
        void'(src_q.pop_front());
        acc_n++;
      end
      if (stall_at >= 0 && acc_n == stall_at) begin
        stall_cnt = stall_len;
        stall_at  = -1;
      end
      if (stall_cnt > 0) begin
        s_valid = 1'b0;
        stall_cnt--;
      end else if (src_q.size() > 0 && $urandom_range(0, 99) >= drop_pct) begin
        s_valid = 1'b1;
        s_data  = src_q[0];
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  task automatic fill_source(input int nbytes, input bit seq);
    logic [7:0] b;
    src_q.delete();
    ref_bytes.delete();
    acc_cyc.delete();
    acc_n = 0;
    for (int i = 0; i < nbytes; i++) begin
      b = seq ? 8'(i) : 8'($urandom);
      src_q.push_back(b);
      ref_bytes.push_back(b);
    end
  endtask

  task automatic run_transfer(input logic [7:0] idx, input int len, input int g,
                              input int nbytes, input int st_at, input int st_len,
                              input int drop, input bit seq, input bit mid_start);
    int exp_n;
    int gmin;
    int spacing;
    bit inj;
    exp_n = (len < nbytes) ? len : nbytes;
    gmin  = (g == 0) ? 1 : g;
    @(posedge clk_sys);
    #1;
    clear_mon();
    fill_source(nbytes, seq);
    stall_at  = st_at;
    stall_len = st_len;
    drop_pct  = drop;
    start  = 1'b1;
    index  = idx;
    length = AW'(len);
    gap    = 4'(g);
    @(posedge clk_sys);
    #1;
    start  = 1'b0;
    index  = ~idx;
    length = AW'($urandom);
    gap    = 4'($urandom);
    chk("busy_after_start", int'(busy), 1);
    chk("download_after_start", int'(ioctl_download), 1);
    inj = 1'b0;
    for (int c = 0; c < 4000 && done_n == 0; c++) begin
      @(posedge clk_sys);
      #1;
      if (start) begin
        start = 1'b0;
      end else if (mid_start && !inj && st_cyc.size() == 1) begin
        start  = 1'b1;
        index  = 8'h5a;
        length = AW'(1);
        inj    = 1'b1;
      end
    end
    start = 1'b0;
    repeat (8) @(posedge clk_sys);
    #1;
    chk("done_count", done_n, 1);
    chk("strobe_count", st_cyc.size(), exp_n);
    chk("accepted_bytes", acc_n, exp_n);
    for (int i = 0; i < st_cyc.size() && i < exp_n; i++) begin
      chk($sformatf("addr[%0d]", i), st_addr[i], i);
      chk($sformatf("dout[%0d]", i), st_data[i], int'(ref_bytes[i]));
      if (i < acc_cyc.size()) chk($sformatf("strobe_after_accept[%0d]", i),
                                  int'(st_cyc[i] > acc_cyc[i]), 1);
      if (i > 0) begin
        spacing = st_cyc[i] - st_cyc[i-1];
        if (drop == 0 && st_len == 0) chk($sformatf("spacing[%0d]", i), spacing, gmin + 1);
        else chk($sformatf("spacing_min[%0d]", i), int'(spacing >= gmin + 1), 1);
      end
    end
    if (exp_n > 0 && st_cyc.size() > 0) begin
      chk("done_latency", done_cyc - st_cyc[st_cyc.size()-1], gmin + 1);
      chk("addr_hold", int'(ioctl_addr), exp_n - 1);
      chk("dout_hold", int'(ioctl_dout), int'(ref_bytes[exp_n-1]));
    end else if (exp_n == 0) begin
      chk("download_cycles", dl_n, 2);
    end
    chk("index_latched", int'(ioctl_index), int'(idx));
    chk("idle_busy", int'(busy), 0);
    chk("idle_download", int'(ioctl_download), 0);
  endtask

  initial begin
    int len;
    int g;
    int nb;
    int sa;
    int sl;
    reset   = 1'b1;
    start   = 1'b0;
    index   = '0;
    length  = '0;
    gap     = '0;
    abort   = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    chk("rst_download", int'(ioctl_download), 0);
    chk("rst_wr", int'(ioctl_wr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_index", int'(ioctl_index), 0);
    chk("rst_addr", int'(ioctl_addr), 0);
    chk("rst_dout", int'(ioctl_dout), 0);

    // Sequential bytes, gap 0, source always valid.
    run_transfer(8'd254, 8, 0, 8, -1, 0, 0, 1'b1, 1'b0);
    // Zero-length transfer.
    run_transfer(8'd9, 0, 3, 0, -1, 0, 0, 1'b0, 1'b0);
    // Long source stall before byte 2.
    run_transfer(8'd1, 3, 5, 3, 2, 20, 0, 1'b0, 1'b0);
    // Source offers more bytes than the transfer length.
    run_transfer(8'd4, 4, 2, 6, -1, 0, 0, 1'b0, 1'b0);

    // Abort on the cycle the third strobe would be issued.
    @(posedge clk_sys);
    #1;
    clear_mon();
    fill_source(12, 1'b0);
    stall_at = -1;
    drop_pct = 0;
    start  = 1'b1;
    index  = 8'h33;
    length = AW'(10);
    gap    = 4'd0;
    @(posedge clk_sys);
    #1;
    start = 1'b0;
    for (int c = 0; c < 200 && st_cyc.size() < 2; c++) begin
      @(posedge clk_sys);
      #1;
    end
    abort = 1'b1;
    @(posedge clk_sys);
    #1;
    abort = 1'b0;
    chk("abort_wr", int'(ioctl_wr), 0);
    chk("abort_download", int'(ioctl_download), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_s_ready", int'(s_ready), 0);
    repeat (10) @(posedge clk_sys);
    #1;
    chk("abort_strobes", st_cyc.size(), 2);
    chk("abort_no_done", done_n, 0);
    chk("abort_addr_hold", int'(ioctl_addr), 1);
    src_q.delete();
    // A fresh transfer must start at address 0 with none of the flushed bytes.
    run_transfer(8'h44, 5, 1, 5, -1, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of a GAP.
    @(posedge clk_sys);
    #1;
    clear_mon();
    fill_source(6, 1'b0);
    start  = 1'b1;
    index  = 8'h99;
    length = AW'(6);
    gap    = 4'd8;
    @(posedge clk_sys);
    #1;
    start = 1'b0;
    for (int c = 0; c < 200 && st_cyc.size() < 1; c++) begin
      @(posedge clk_sys);
      #1;
    end
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    chk("mid_rst_download", int'(ioctl_download), 0);
    chk("mid_rst_wr", int'(ioctl_wr), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_s_ready", int'(s_ready), 0);
    chk("mid_rst_index", int'(ioctl_index), 0);
    chk("mid_rst_addr", int'(ioctl_addr), 0);
    chk("mid_rst_dout", int'(ioctl_dout), 0);
    repeat (20) @(posedge clk_sys);
    #1;
    chk("mid_rst_strobes", st_cyc.size(), 1);
    chk("mid_rst_no_done", done_n, 0);
    src_q.delete();

    // A start pulse while busy must not disturb the running transfer.
    run_transfer(8'h21, 4, 3, 4, -1, 0, 10, 1'b0, 1'b1);

    // Abort together with start in IDLE: start is ignored.
    @(posedge clk_sys);
    #1;
    clear_mon();
    start  = 1'b1;
    abort  = 1'b1;
    index  = 8'h77;
    length = AW'(3);
    @(posedge clk_sys);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_download", int'(ioctl_download), 0);
    chk("abort_start_busy", int'(busy), 0);
    chk("abort_start_index", int'(ioctl_index), 8'h21);

    // Randomized transfers.
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(1, 12);
      g   = $urandom_range(0, 15);
      nb  = len + $urandom_range(0, 3);
      sl  = $urandom_range(0, 1) == 1 ? $urandom_range(1, 8) : 0;
      sa  = (sl > 0) ? $urandom_range(0, len - 1) : -1;
      run_transfer(8'($urandom), len, g, nb, sa, sl, $urandom_range(0, 40), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ioctl_tx.md
IOCTL_TX -- requirements
Module: ioctl_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, power-of-two byte-FIFO depth (min 2).
REQ-002 SHALL have parameter ADDR_W, default 25, ioctl address width.
REQ-003 SHALL have port clk_sys  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a transfer, sampled only in IDLE.
REQ-006 SHALL have port index  in  8  transfer index, latched at start.
REQ-007 SHALL have port length  in  ADDR_W  byte count, latched at start; 0 is legal.
REQ-008 SHALL have port gap  in  4  idle cycles between write strobes, latched at start; 0 treated as 1.
REQ-009 SHALL have port abort  in  1  cancels the active transfer.
REQ-010 SHALL have port s_data  in  8  source byte.
REQ-011 SHALL have port s_valid  in  1  source byte valid.
REQ-012 SHALL have port s_ready  out  1  byte accepted when s_valid&s_ready.
REQ-013 SHALL have port ioctl_download  out  1  transfer-active framing.
REQ-014 SHALL have port ioctl_index  out  8  latched index.
REQ-015 SHALL have port ioctl_wr  out  1  one-cycle write strobe.
REQ-016 SHALL have port ioctl_addr  out  ADDR_W  byte address of current strobe.
REQ-017 SHALL have port ioctl_dout  out  8  byte of current strobe.
REQ-018 SHALL have port busy  out  1  high in every state except IDLE.
REQ-019 SHALL have port done  out  1  one-cycle pulse on normal completion.

Function
REQ-020 SHALL implement states IDLE, PRE, WRITE, GAP, POST; all outputs registered.
REQ-021 IDLE + start: latch index/length/gap, clear byte counters, go PRE; ioctl_download=1 next cycle.
REQ-022 PRE lasts exactly 1 cycle (setup), then WRITE; if length==0 go POST instead.
REQ-023 WRITE: when FIFO non-empty, pop one byte, assert ioctl_wr for 1 cycle with ioctl_addr=write count (first 0) and ioctl_dout=byte, then go GAP; if FIFO empty stay WRITE with ioctl_wr=0.
REQ-024 GAP counts max(gap,1) cycles, then WRITE if writes<length else POST.
REQ-025 ioctl_addr and ioctl_dout SHALL hold their values from a strobe until the next strobe or reset.
REQ-026 POST lasts 1 cycle with ioctl_download=1; next cycle ioctl_download=0, done=1, state IDLE.
REQ-027 s_ready SHALL be 1 only when busy, FIFO not full, and accepted count<length; excess source bytes are never taken.
REQ-028 Push and pop in the same cycle SHALL both occur; occupancy unchanged.
REQ-029 Consecutive strobes SHALL be separated by at least max(gap,1) cycles of ioctl_wr=0.
REQ-030 start while busy SHALL be ignored.
REQ-031 abort while busy: next cycle state IDLE, ioctl_download=0, ioctl_wr=0, FIFO flushed, done stays 0; abort has priority over a same-cycle strobe (strobe suppressed, byte discarded).
REQ-032 abort and start in the same IDLE cycle: start ignored.
REQ-033 Counters SHALL be ADDR_W bits; length up to 2^ADDR_W-1 without wrap.

Reset
REQ-034 On reset: state IDLE; ioctl_download, ioctl_wr, busy, done, s_ready=0; ioctl_index, ioctl_addr, ioctl_dout=0; FIFO empty; counters 0.
REQ-035 Reset mid-transfer SHALL behave as abort in the following cycle (no done, no further strobes).

Structure
REQ-036 State enum and default widths (ADDR_W=25, index 8) SHALL live in shared package ioctl_pkg.
REQ-037 Byte FIFO SHALL be one sub-module, ioctl_tx_fifo (FIFO_DEPTH x 8, registered full/empty, flush input).

Verification
REQ-038 start, index=254, length=8, gap=0, bytes 0x00..0x07 always valid -> 8 strobes, addr 0..7, dout 0x00..0x07, 1 idle cycle between strobes, done 2 cycles after last strobe.
REQ-039 start, length=0 -> ioctl_download high exactly 2 cycles (PRE, POST), no ioctl_wr, one done pulse.
REQ-040 index=1, length=3, gap=5, s_valid stalled 20 cycles before byte 2 -> no strobe during stall, strobes >=6 cycles apart, addr 0,1,2.
REQ-041 length=4, source offers 6 bytes -> exactly 4 accepted (s_ready low after 4th), 4 strobes.
REQ-042 abort asserted on cycle of 3rd strobe of length=10 -> that strobe suppressed, download low next cycle, no done, FIFO empty; new start then runs cleanly from addr 0.
REQ-043 reset asserted mid-GAP -> all outputs reset values next cycle; start issued while busy is ignored.
